// File: rtl/mem_rsp_responder.sv
// Word-organised SRAM responder: valid/ready request bus in, in-order read data out.
// Define MEM_RSP_ERR_EN to add rsp_err and reject misaligned accesses.
module mem_rsp_responder #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int DEPTH_W = 16384,
    parameter int LAT     = 2,
    parameter int QD      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic              req_we,
    input  logic [DW/8-1:0]   req_wmask,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
`ifdef MEM_RSP_ERR_EN
    output logic              rsp_err,
`endif
    output logic [DW-1:0]     rsp_data
);

    localparam int NB = DW / 8;
    localparam int IW = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
    localparam int QW = (QD > 1) ? $clog2(QD) : 1;
    localparam int CW = $clog2(QD + 1);
`ifdef MEM_RSP_ERR_EN
    localparam int PW = DW + 1;
`else
    localparam int PW = DW;
`endif

    logic [DW-1:0]   mem [DEPTH_W];
    logic [AW-3:0]   word_addr;
    logic [IW-1:0]   widx;
    logic            accept;
    logic            rd_fire;
    logic            wr_fire;
    logic            pop;
    logic [PW-1:0]   rd_word;
    logic            push_v;
    logic [PW-1:0]   push_w;

    logic [PW-1:0]   fifo [QD];
    logic [QW-1:0]   wr_ptr;
    logic [QW-1:0]   rd_ptr;
    logic [CW-1:0]   fill;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [DW-1:0]   last_q;

    assign word_addr = req_addr[AW-1:2];
    assign widx      = IW'(word_addr);
    assign accept    = req_valid && req_ready;
    assign rd_fire   = accept && !req_we;
    assign pop       = rsp_valid && rsp_ready;

`ifdef MEM_RSP_ERR_EN
    logic misaligned;
    assign misaligned = |req_addr[1:0];
    assign rd_word    = misaligned ? {1'b1, {DW{1'b0}}} : {1'b0, mem[widx]};
    assign wr_fire    = accept && req_we && !misaligned;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign rd_word         = mem[widx];
    assign wr_fire         = accept && req_we;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (req_wmask[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // The memory read itself is the first latency cycle; LAT-1 further stages follow.
    if (LAT == 1) begin : g_no_delay
        assign push_v = rd_fire;
        assign push_w = rd_word;
    end else begin : g_delay
        logic [LAT-2:0]  dv;
        logic [PW-1:0]   dd [LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                dv <= '0;
            end else begin
                dv[0] <= rd_fire;
                for (int unsigned k = 1; k < LAT - 1; k++) dv[k] <= dv[k-1];
            end
        end

        always_ff @(posedge clk) begin
            dd[0] <= rd_word;
            for (int unsigned k = 1; k < LAT - 1; k++) dd[k] <= dd[k-1];
        end

        assign push_v = dv[LAT-2];
        assign push_w = dd[LAT-2];
    end

    always_ff @(posedge clk) begin
        if (push_v) fifo[wr_ptr] <= push_w;
    end

    always_comb begin
        outstanding_next = outstanding;
        if (rd_fire && !pop)      outstanding_next = outstanding + 1'b1;
        else if (!rd_fire && pop) outstanding_next = outstanding - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready   <= 1'b0;
            outstanding <= '0;
            fill        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_q      <= '0;
        end else begin
            outstanding <= outstanding_next;
            req_ready   <= (outstanding_next < CW'(QD));
            if (push_v && !pop)      fill <= fill + 1'b1;
            else if (!push_v && pop) fill <= fill - 1'b1;
            if (push_v) wr_ptr <= (wr_ptr == QW'(QD - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= (rd_ptr == QW'(QD - 1)) ? '0 : rd_ptr + 1'b1;
                last_q <= fifo[rd_ptr][DW-1:0];
            end
        end
    end

    // An empty FIFO shows the most recently popped word rather than a stale slot.
    assign rsp_valid = (fill != '0);
    assign rsp_data  = rsp_valid ? fifo[rd_ptr][DW-1:0] : last_q;
`ifdef MEM_RSP_ERR_EN
    assign rsp_err   = rsp_valid && fifo[rd_ptr][DW];
`endif

endmodule

// File: tb/tb_mem_rsp_responder.sv
// Directed self-checking bench for mem_rsp_responder (LAT=2, QD=4).
module tb_mem_rsp_responder;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [3:0]    req_wmask;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
`ifdef MEM_RSP_ERR_EN
    logic          rsp_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_rsp_responder #(
        .AW(AW), .DW(DW), .DEPTH_W(16384), .LAT(2), .QD(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef MEM_RSP_ERR_EN
        .rsp_err(rsp_err),
`endif
        .rsp_data(rsp_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for ready, let it be accepted, then drop valid.
    task automatic issue(input logic [AW-1:0] a, input logic we, input logic [3:0] m,
                         input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1; req_addr = a; req_we = we; req_wmask = m; req_wdata = d;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_arrives", rsp_valid, 1);
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        issue(a, 1'b0, 4'h0, '0);
        wait_rsp();
        chk(tag, rsp_data, exp);
        step();
    endtask

    initial begin
        int rcvd, issued, outst, max_out;

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
        req_wmask = '0; req_wdata = '0; rsp_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", rsp_valid, 0);
        end
        chk("rst_data", rsp_data, 0);
        rst = 1'b0; req_valid = 1'b0;
        step();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);

        issue(16'h1000, 1'b1, 4'hF, 32'hDEADBEEF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1000;
        chk("rd_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("lat_n1_valid", rsp_valid, 0);
        step();
        chk("lat_valid", rsp_valid, 1);
        chk("lat_data", rsp_data, 32'hDEADBEEF);
        step();
        chk("stall_hold_valid", rsp_valid, 1);
        chk("stall_hold_data", rsp_data, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        step();
        chk("pop_empty_valid", rsp_valid, 0);
        chk("empty_hold_data", rsp_data, 32'hDEADBEEF);

        issue(16'h1000, 1'b1, 4'h1, 32'h000000AA);
        rd_check(16'h1000, 32'hDEADBEAA, "mask_merge");

        for (int k = 0; k < 5; k++) issue(16'(k * 4), 1'b1, 4'hF, 32'h11110000 + k);
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 16'(k * 4);
            chk("b2b_ready", req_ready, 1);
            step();
        end
        chk("full_ready", req_ready, 0);
        req_addr = 16'h0010;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("held_ready", req_ready, 0);
            chk("full_valid", rsp_valid, 1);
            chk("full_stall_data", rsp_data, 32'h11110000);
        end
        rsp_ready = 1'b1;
        step();
        chk("ready_after_pop", req_ready, 1);
        chk("order1", rsp_data, 32'h11110001);
        step();
        req_valid = 1'b0;
        chk("order2", rsp_data, 32'h11110002);
        step();
        chk("order3", rsp_data, 32'h11110003);
        step();
        chk("order4_fifth", rsp_data, 32'h11110004);
        step();
        chk("drain_valid", rsp_valid, 0);
        chk("drain_hold", rsp_data, 32'h11110004);

        for (int k = 0; k < 16; k++) issue(16'(k * 4), 1'b1, 4'hF, 32'hA5000000 + k);
        rcvd = 0; issued = 0; outst = 0; max_out = 0;
        for (int cyc = 0; cyc < 200 && rcvd < 16; cyc++) begin
            req_valid = (issued < 16); req_we = 1'b0; req_addr = 16'(issued * 4);
            rsp_ready = cyc[0];
            if (rsp_valid && rsp_ready) begin
                chk("stream_data", rsp_data, 32'hA5000000 + rcvd);
                rcvd++;
                outst--;
            end
            if (req_valid && req_ready) begin
                issued++;
                outst++;
                if (outst > max_out) max_out = outst;
            end
            step();
        end
        req_valid = 1'b0;
        chk("stream_count", rcvd, 16);
        chk("stream_max_out_le_qd", (max_out <= 4), 1);
        chk("stream_idle", rsp_valid, 0);

        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) issue(16'(k * 4), 1'b0, 4'h0, '0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_data", rsp_data, 0);
        chk("midrst_ready", req_ready, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        chk("midrst_ready_back", req_ready, 1);
        rd_check(16'h1000, 32'hDEADBEAA, "mem_retained");

`ifdef MEM_RSP_ERR_EN
        issue(16'h1002, 1'b0, 4'h0, '0);
        wait_rsp();
        chk("misalign_rd_data", rsp_data, 0);
        chk("misalign_rd_err", rsp_err, 1);
        step();
        issue(16'h1001, 1'b1, 4'hF, 32'h12345678);
        issue(16'h1000, 1'b0, 4'h0, '0);
        wait_rsp();
        chk("misalign_wr_dropped", rsp_data, 32'hDEADBEAA);
        chk("aligned_rd_err", rsp_err, 0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
